// File: rtl/div16_seq_if.sv
// ---------------------------------------------------------------------------
// div16_seq_if
//   Handshake/operand bundle between the exec unit (master) and the iterative
//   32/16 divider (slave).
//
//   start      exec -> div   start request, sampled only while the divider idles
//   dividend   exec -> div   32-bit numerator {DX,AX}
//   divisor    exec -> div   16-bit denominator
//   signed_op  exec -> div   1 = IDIV (only when DIV16_SIGNED_EN is defined)
//   quotient   div -> exec   result quotient (AX)
//   remainder  div -> exec   result remainder (DX)
//   busy       div -> exec   operation in flight; exec stalls on it
//   done       div -> exec   one-cycle completion pulse
//   div_zero   div -> exec   divisor was zero
//   div_ovf    div -> exec   quotient out of range
//
//   Optional feature macro: DIV16_SIGNED_EN
// ---------------------------------------------------------------------------
interface div16_seq_if;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
`ifdef DIV16_SIGNED_EN
    logic        signed_op;
`endif
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        div_ovf;

    modport master (
        output start, dividend, divisor,
`ifdef DIV16_SIGNED_EN
        output signed_op,
`endif
        input  quotient, remainder, busy, done, div_zero, div_ovf
    );

    modport slave (
        input  start, dividend, divisor,
`ifdef DIV16_SIGNED_EN
        input  signed_op,
`endif
        output quotient, remainder, busy, done, div_zero, div_ovf
    );
endinterface

// File: rtl/div16_seq.sv
// ---------------------------------------------------------------------------
// div16_seq
//   Iterative 32/16 restoring divider for the ALU DIV path. One 16-bit
//   subtractor (adder in borrow mode) is reused over 16 steps. Produces
//   quotient/remainder, or a divide-error flag consumed by INT 0 microcode.
//
//   Ports
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset; aborts any operation in flight
//     bus    slave side of div16_seq_if (start/operands in, results/flags out)
//
//   Sequence: IDLE -start-> CHECK -> ITER x16 -> FIN -> IDLE
//             CHECK with an error goes straight to FIN.
//   Latency from the start-sampling cycle to done: 18 (normal), 2 (error).
//
//   Optional feature macro: DIV16_SIGNED_EN
//     Adds bus.signed_op (IDIV). Operands are divided as magnitudes and the
//     signs are applied to the result on the final step. Without the macro
//     the divider is unsigned only.
// ---------------------------------------------------------------------------
module div16_seq (
    input  logic       clk,
    input  logic       rst_n,
    div16_seq_if.slave bus
);
    localparam int ITER = 16;
    localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ITER,
        S_FIN
    } state_t;

    state_t      state, state_nxt;

    // Captured operands; dvs_q is replaced by its magnitude in CHECK.
    logic [31:0] dvd_q;
    logic [15:0] dvs_q;
    logic        sop_q;
    logic        sgn_dvd_q;
    logic        sgn_dvs_q;

    // Partial remainder and quotient. The 17th remainder bit only exists
    // transiently after the shift and is never stored: a restoring step
    // always leaves the remainder below the divisor.
    logic [15:0] r_q;
    logic [15:0] q_q;
    logic [3:0]  cnt_q;

    logic [15:0] quo_q;
    logic [15:0] rem_q;
    logic        zero_q;
    logic        ovf_q;

    logic        busy;
    logic        done;

    logic        signed_in;
`ifdef DIV16_SIGNED_EN
    assign signed_in = bus.signed_op;
`else
    assign signed_in = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // CHECK: operand magnitudes and error detection
    // ---------------------------------------------------------------------
    logic [31:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic        chk_zero;
    logic        chk_ovf;

    always_comb begin
        dvd_mag  = sgn_dvd_q ? -dvd_q : dvd_q;
        dvs_mag  = sgn_dvs_q ? -dvs_q : dvs_q;
        chk_zero = (dvs_q == 16'h0000);
        chk_ovf  = !chk_zero && (dvd_mag[31:16] >= dvs_mag);
    end

    // ---------------------------------------------------------------------
    // ITER: one restoring step through the shared subtractor
    // ---------------------------------------------------------------------
    logic [16:0] r_sh;
    logic [15:0] q_sh;
    logic [15:0] add_y;
    logic [15:0] add_z;
    logic        add_c;
    logic        add_co;
    logic        qb;
    logic [15:0] r_nxt;
    logic [15:0] q_nxt;

    // Final-step sign fix-up
    logic        neg_q;
    logic [15:0] q_fin;
    logic [15:0] r_fin;
    logic        ovf_fin;

    // NOTE: every signal written in an always_comb gets a value on every
    // path (here unconditionally) so no latch is inferred.
    always_comb begin
        r_sh   = {r_q, q_q[15]};
        q_sh   = {q_q[14:0], 1'b0};

        // x - d as x + ~d + 1; in borrow mode the carry-out is inverted,
        // so add_co = 1 means x < d.
        add_y          = ~dvs_q;
        {add_c, add_z} = {1'b0, r_sh[15:0]} + {1'b0, add_y} + 17'd1;
        add_co         = ~add_c;

        qb     = r_sh[16] | ~add_co;
        r_nxt  = qb ? add_z : r_sh[15:0];
        q_nxt  = {q_sh[15:1], qb};

        neg_q  = sgn_dvd_q ^ sgn_dvs_q;
        q_fin  = neg_q     ? -q_nxt : q_nxt;
        r_fin  = sgn_dvd_q ? -r_nxt : r_nxt;
        // A negative result may reach -0x8000; a positive one only 0x7FFF.
        ovf_fin = sop_q && (neg_q ? (q_nxt > 16'h8000) : (q_nxt > 16'h7FFF));
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_CHECK;
            S_CHECK: begin
                busy      = 1'b1;
                state_nxt = (chk_zero || chk_ovf) ? S_FIN : S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers. Results are written on the edge that enters FIN,
    // so they are already valid while done is high and then simply hold.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            sop_q     <= 1'b0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        dvd_q     <= bus.dividend;
                        dvs_q     <= bus.divisor;
                        sop_q     <= signed_in;
                        sgn_dvd_q <= signed_in & bus.dividend[31];
                        sgn_dvs_q <= signed_in & bus.divisor[15];
                        zero_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                    end
                end
                S_CHECK: begin
                    cnt_q <= '0;
                    r_q   <= dvd_mag[31:16];
                    q_q   <= dvd_mag[15:0];
                    dvs_q <= dvs_mag;
                    if (chk_zero) begin
                        zero_q <= 1'b1;
                        quo_q  <= '0;
                        rem_q  <= '0;
                    end else if (chk_ovf) begin
                        ovf_q  <= 1'b1;
                        quo_q  <= '0;
                        rem_q  <= '0;
                    end
                end
                S_ITER: begin
                    r_q   <= r_nxt;
                    q_q   <= q_nxt;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        if (ovf_fin) begin
                            ovf_q <= 1'b1;
                            quo_q <= '0;
                            rem_q <= '0;
                        end else begin
                            quo_q <= q_fin;
                            rem_q <= r_fin;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.div_zero  = zero_q;
    assign bus.div_ovf   = ovf_q;

endmodule

// File: tb/tb_div16_seq.sv
// ---------------------------------------------------------------------------
// tb_div16_seq
//   Directed bench for div16_seq: a table of operand/expected-result records
//   plus hand-written sequences for start-while-busy and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_div16_seq;
    logic clk;
    logic rst_n;

    div16_seq_if bus ();

    div16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic        sop;
        logic [15:0] q;
        logic [15:0] r;
        logic        zero;
        logic        ovf;
        int          lat;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one operation and follows it to done. pulse_at > 0 raises start
    // for one cycle at that cycle offset while the divider is busy.
    task automatic run_op(input vec_t v, input int pulse_at, input string name);
        int n;
        int busy_n;
        int extra;
        bit seen;
        logic [15:0] q_at_done;

        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = v.dvd;
        bus.divisor  = v.dvs;
`ifdef DIV16_SIGNED_EN
        bus.signed_op = v.sop;
`endif
        @(negedge clk);              // start sampled at the edge in between
        bus.start    = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;  // operand changes must not matter
        bus.divisor  = 16'h0000;

        n = 1;
        busy_n = 0;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            if (n == 1) begin
                check({name, ".flags_clr"}, {30'd0, bus.div_zero, bus.div_ovf}, 32'd0);
            end
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_n++;
                bus.start = (n == pulse_at);
                @(negedge clk);
                n++;
            end
        end
        bus.start = 1'b0;

        check({name, ".done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({name, ".latency"}, n, v.lat);
            check({name, ".busy_cycles"}, busy_n, v.lat - 1);
            check({name, ".busy_at_done"}, {31'd0, bus.busy}, 32'd0);
            check({name, ".quotient"}, {16'd0, bus.quotient}, {16'd0, v.q});
            check({name, ".remainder"}, {16'd0, bus.remainder}, {16'd0, v.r});
            check({name, ".div_zero"}, {31'd0, bus.div_zero}, {31'd0, v.zero});
            check({name, ".div_ovf"}, {31'd0, bus.div_ovf}, {31'd0, v.ovf});
            q_at_done = bus.quotient;

            extra = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bus.done || bus.busy) extra++;
            end
            check({name, ".no_extra_op"}, extra, 0);
            check({name, ".q_hold"}, {16'd0, bus.quotient}, {16'd0, q_at_done});
        end
    endtask

    vec_t vecs[$];
    vec_t v_norm;
    vec_t v_zero;

    initial begin
        // {dividend, divisor, signed_op, quotient, remainder, zero, ovf, latency}
        vecs.push_back(vec_t'{32'h0000_0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'hFFFE_FFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'h1234_5678, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 2});
        vecs.push_back(vec_t'{32'h0000_0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'h0001_0000, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2});
        vecs.push_back(vec_t'{32'h0000_FFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'h1234_5678, 16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2});
        vecs.push_back(vec_t'{32'h0000_03E8, 16'h000A, 1'b0, 16'h0064, 16'h0000, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'h0FFF_FFFF, 16'h1000, 1'b0, 16'hFFFF, 16'h0FFF, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'h0000_0005, 16'h0009, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'hFFFF_FF9C, 16'h0007, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2});
`ifdef DIV16_SIGNED_EN
        vecs.push_back(vec_t'{32'hFFFF_FF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'h0000_8000, 16'h0001, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 18});
        vecs.push_back(vec_t'{32'hFFFF_8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'h0000_0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 18});
        vecs.push_back(vec_t'{32'h0000_0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 2});
`endif
        v_norm = vecs[0];
        v_zero = vecs[2];

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIV16_SIGNED_EN
        bus.signed_op = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst.quotient",  {16'd0, bus.quotient},  32'd0);
        check("rst.remainder", {16'd0, bus.remainder}, 32'd0);
        check("rst.busy",      {31'd0, bus.busy},      32'd0);
        check("rst.done",      {31'd0, bus.done},      32'd0);
        check("rst.div_zero",  {31'd0, bus.div_zero},  32'd0);
        check("rst.div_ovf",   {31'd0, bus.div_ovf},   32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], 0, $sformatf("v%0d", i));
        end

        // Start pulsed while busy, then an error followed by a clean op.
        run_op(v_norm, 5, "busy_start");
        run_op(v_zero, 0, "zero_again");
        run_op(v_norm, 0, "after_zero");

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'h0000_0005;
        bus.divisor  = 16'h0003;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);   // now at cycle +9
        rst_n = 1'b0;
        #1;
        check("midrst.quotient",  {16'd0, bus.quotient},  32'd0);
        check("midrst.remainder", {16'd0, bus.remainder}, 32'd0);
        check("midrst.busy",      {31'd0, bus.busy},      32'd0);
        check("midrst.done",      {31'd0, bus.done},      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int dones;
            dones = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.done) dones++;
            end
            check("midrst.no_done", dones, 0);
        end
        run_op(v_norm, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
